// File: rtl/sa_layer_sequencer.sv
// Run-level controller for the systolic array: streams weights and feature
// bytes into the array's shared write port layer by layer, kicks the array,
// counts accumulator-valid pulses for completion, and steps through the
// configured conv-layer range, reporting done or error.
//
// Stream handshake: a byte transfers on every rising clk edge where
// s_valid && s_ready are both high; s_ready depends only on the current
// state, never on s_valid, and s_data must be stable while s_valid is high.
module sa_layer_sequencer #(
    parameter int TIMEOUT_CYC = 65535,
    parameter int CNT_W       = 17
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_start,
    input  logic        cmd_abort,
    input  logic [1:0]  cfg_first_layer,
    input  logic [1:0]  cfg_last_layer,
    input  logic [10:0] cfg_wgt_len,
    input  logic [14:0] cfg_dat_len,
    input  logic        s_valid,
    input  logic [7:0]  s_data,
    output logic        s_ready,
    output logic        wea,
    output logic [16:0] addra,
    output logic [7:0]  dia,
    output logic        sa_start,
    output logic [1:0]  nth_conv,
    input  logic        accu_valid_i,
    output logic        busy,
    output logic [1:0]  cur_layer,
    output logic        layer_done,
    output logic        run_done,
    output logic        err
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD_W  = 3'd1,
        LOAD_D  = 3'd2,
        DRAIN   = 3'd3,
        KICK    = 3'd4,
        COMPUTE = 3'd5,
        NEXT    = 3'd6
    } state_t;

    localparam logic [CNT_W-1:0] TMO_LIM = CNT_W'(TIMEOUT_CYC);

    // state is kept as a plain named signal so checkers can bind to it
    state_t            state;
    state_t            state_d;

    logic [1:0]        last_layer;
    logic [10:0]       wgt_len;
    logic [14:0]       dat_len;
    logic [10:0]       wcnt;
    logic [14:0]       dcnt;
    logic [10:0]       ocnt;
    logic [CNT_W-1:0]  tcnt;
    logic              cfg_err;

    logic              hs;
    logic              cfg_bad;
    logic              start_ok;
    logic              w_last;
    logic              d_last;
    logic              comp_done;
    logic              tmo;
    logic [10:0]       exp_cnt;

    // per-layer output count of the array and the decode helpers
    always_comb begin
        exp_cnt = 11'd0;
        case (cur_layer)
            2'd0:    exp_cnt = 11'd1024;
            2'd1:    exp_cnt = 11'd784;
            2'd2:    exp_cnt = 11'd196;
            default: exp_cnt = 11'd0;
        endcase
        cfg_bad   = (cfg_first_layer > cfg_last_layer) || (cfg_last_layer == 2'd3) ||
                    (cfg_wgt_len == 11'd0) || (cfg_wgt_len > 11'd1024) ||
                    (cfg_dat_len == 15'd0) || (cfg_dat_len > 15'd25600);
        start_ok  = (state == IDLE) && cmd_start && !cmd_abort && !cfg_bad;
        hs        = s_valid && s_ready;
        w_last    = (wcnt == wgt_len - 11'd1);
        d_last    = (dcnt == dat_len - 15'd1);
        comp_done = (state == COMPUTE) && (ocnt == exp_cnt);
        // completion wins over a timeout landing on the same cycle
        tmo       = (state == COMPUTE) && !comp_done && (tcnt == TMO_LIM);
    end

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    // next state and state-decoded outputs; abort overrides every transition
    always_comb begin
        state_d    = state;
        s_ready    = 1'b0;
        sa_start   = 1'b0;
        nth_conv   = 2'd0;
        busy       = (state != IDLE);
        layer_done = comp_done;
        run_done   = (state == NEXT) && (cur_layer == last_layer);
        err        = cfg_err || tmo;
        case (state)
            LOAD_W, LOAD_D: s_ready = 1'b1;
            KICK: begin
                sa_start = 1'b1;
                nth_conv = cur_layer;
            end
            COMPUTE: nth_conv = cur_layer;
            default: ;
        endcase
        if (cmd_abort) begin
            state_d = IDLE;
        end else begin
            case (state)
                IDLE:    if (start_ok) state_d = LOAD_W;
                LOAD_W:  if (hs && w_last) state_d = LOAD_D;
                LOAD_D:  if (hs && d_last) state_d = DRAIN;
                DRAIN:   state_d = KICK;
                KICK:    state_d = COMPUTE;
                COMPUTE: begin
                    if (comp_done) state_d = NEXT;
                    else if (tmo)  state_d = IDLE;
                end
                NEXT:    state_d = (cur_layer == last_layer) ? IDLE : LOAD_W;
                default: state_d = IDLE;
            endcase
        end
    end

    // config latch, byte counters, registered write port, completion counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_layer <= 2'd0;
            wgt_len    <= 11'd0;
            dat_len    <= 15'd0;
            cur_layer  <= 2'd0;
            wcnt       <= 11'd0;
            dcnt       <= 15'd0;
            ocnt       <= 11'd0;
            tcnt       <= '0;
            cfg_err    <= 1'b0;
            wea        <= 1'b0;
            addra      <= 17'd0;
            dia        <= 8'd0;
        end else begin
            cfg_err <= (state == IDLE) && cmd_start && !cmd_abort && cfg_bad;
            // a byte accepted in the abort cycle never reaches the array
            wea     <= hs && !cmd_abort;
            if (hs) begin
                dia   <= s_data;
                addra <= (state == LOAD_W) ? {2'b01, 5'b0, wcnt[9:0]} : {2'b00, dcnt};
            end

            if (start_ok) begin
                last_layer <= cfg_last_layer;
                wgt_len    <= cfg_wgt_len;
                dat_len    <= cfg_dat_len;
                cur_layer  <= cfg_first_layer;
            end

            if (cmd_abort || start_ok) begin
                wcnt <= 11'd0;
                dcnt <= 15'd0;
            end else begin
                if (state == LOAD_W && hs) wcnt <= w_last ? 11'd0 : wcnt + 11'd1;
                if (state == LOAD_D && hs) dcnt <= d_last ? 15'd0 : dcnt + 15'd1;
            end

            if (state == COMPUTE) begin
                tcnt <= tcnt + CNT_W'(1);
                if (accu_valid_i && ocnt != exp_cnt) ocnt <= ocnt + 11'd1;
            end else begin
                tcnt <= '0;
                ocnt <= 11'd0;
            end

            if (state == NEXT && !cmd_abort && cur_layer != last_layer)
                cur_layer <= cur_layer + 2'd1;
        end
    end

endmodule

// File: tb/tb_sa_layer_sequencer.sv
// Directed-plus-random bench for sa_layer_sequencer. A second instance with a
// short timeout shares all inputs so the timeout path can be exercised.
module tb_sa_layer_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_start = 1'b0;
    logic        cmd_abort = 1'b0;
    logic [1:0]  cfg_first_layer = 2'd0;
    logic [1:0]  cfg_last_layer = 2'd0;
    logic [10:0] cfg_wgt_len = 11'd0;
    logic [14:0] cfg_dat_len = 15'd0;
    logic        s_valid = 1'b0;
    logic [7:0]  s_data = 8'd0;
    logic        accu_valid_i = 1'b0;

    logic        s_ready, wea, sa_start, busy, layer_done, run_done, err;
    logic [16:0] addra;
    logic [7:0]  dia;
    logic [1:0]  nth_conv, cur_layer;

    logic        t_s_ready, t_wea, t_sa_start, t_busy, t_layer_done, t_run_done, t_err;
    logic [16:0] t_addra;
    logic [7:0]  t_dia;
    logic [1:0]  t_nth_conv, t_cur_layer;

    int tests = 0;
    int fails = 0;
    int kicks = 0;
    logic [24:0] exp_q[$];
    int exp_ocnt[3] = '{1024, 784, 196};

    sa_layer_sequencer dut (
        .clk(clk), .rst(rst), .cmd_start(cmd_start), .cmd_abort(cmd_abort),
        .cfg_first_layer(cfg_first_layer), .cfg_last_layer(cfg_last_layer),
        .cfg_wgt_len(cfg_wgt_len), .cfg_dat_len(cfg_dat_len),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .wea(wea), .addra(addra), .dia(dia), .sa_start(sa_start), .nth_conv(nth_conv),
        .accu_valid_i(accu_valid_i), .busy(busy), .cur_layer(cur_layer),
        .layer_done(layer_done), .run_done(run_done), .err(err)
    );

    sa_layer_sequencer #(.TIMEOUT_CYC(100)) dut_t (
        .clk(clk), .rst(rst), .cmd_start(cmd_start), .cmd_abort(cmd_abort),
        .cfg_first_layer(cfg_first_layer), .cfg_last_layer(cfg_last_layer),
        .cfg_wgt_len(cfg_wgt_len), .cfg_dat_len(cfg_dat_len),
        .s_valid(s_valid), .s_data(s_data), .s_ready(t_s_ready),
        .wea(t_wea), .addra(t_addra), .dia(t_dia), .sa_start(t_sa_start), .nth_conv(t_nth_conv),
        .accu_valid_i(accu_valid_i), .busy(t_busy), .cur_layer(t_cur_layer),
        .layer_done(t_layer_done), .run_done(t_run_done), .err(t_err)
    );

    // clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // scoreboard: every write on the main instance must match the model queue
    always @(negedge clk) begin
        if (wea) begin
            if (exp_q.size() == 0) check("unexpected_write", {31'd0, wea}, 32'd0);
            else check("write", {7'd0, addra, dia}, {7'd0, exp_q.pop_front()});
        end
        if (sa_start) kicks++;
    end

    task automatic start_cmd(input logic [1:0] f, input logic [1:0] l,
                             input logic [10:0] wl, input logic [14:0] dl);
        @(negedge clk);
        cfg_first_layer = f;
        cfg_last_layer  = l;
        cfg_wgt_len     = wl;
        cfg_dat_len     = dl;
        cmd_start       = 1'b1;
        @(negedge clk);
        cmd_start = 1'b0;
    endtask

    // offers bytes until 'limit' are accepted; the model address is derived
    // from the byte's position in the layer (weights first, then data)
    task automatic stream_layer(input int wl, input int limit, input bit seq, input bit gappy);
        int k;
        int cyc;
        k = 0;
        cyc = 0;
        while (k < limit && cyc < 50 * limit + 100) begin
            @(negedge clk);
            cyc++;
            s_valid = gappy ? ($urandom_range(0, 3) != 0) : 1'b1;
            s_data  = seq ? 8'(k + 1) : 8'($urandom_range(0, 255));
            if (s_valid && s_ready) begin
                if (k < wl) exp_q.push_back({17'h08000 + 17'(k), s_data});
                else        exp_q.push_back({17'(k - wl), s_data});
                k++;
            end
        end
        check("stream_accepted", k, limit);
    endtask

    task automatic wait_kick(input int layer);
        int c;
        c = 0;
        while (!sa_start && c < 50) begin
            @(negedge clk);
            c++;
        end
        check("kick_seen", {31'd0, sa_start}, 32'd1);
        check("kick_layer", {30'd0, nth_conv}, layer);
    endtask

    task automatic pulse_accu(input int n, input bit gappy, output bit early);
        int i;
        i = 0;
        early = 1'b0;
        while (i < n) begin
            @(negedge clk);
            if (layer_done) early = 1'b1;
            accu_valid_i = gappy ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (accu_valid_i) i++;
        end
        @(negedge clk);
        accu_valid_i = 1'b0;
    endtask

    task automatic wait_flag(input string tag, input bit run_flag, input int budget);
        int c;
        c = 0;
        while (!(run_flag ? run_done : layer_done) && c < budget) begin
            @(negedge clk);
            c++;
        end
        check(tag, {31'd0, run_flag ? run_done : layer_done}, 32'd1);
    endtask

    task automatic do_run(input logic [1:0] f, input logic [1:0] l, input int wl,
                          input int dl, input bit seq, input bit gappy);
        bit early;
        int k0;
        k0 = kicks;
        start_cmd(f, l, 11'(wl), 15'(dl));
        for (int layer = f; layer <= l; layer++) begin
            stream_layer(wl, wl + dl, seq, gappy);
            @(negedge clk);
            s_valid = 1'b0;
            wait_kick(layer);
            pulse_accu(exp_ocnt[layer], gappy, early);
            check("no_early_layer_done", {31'd0, early}, 32'd0);
            wait_flag("layer_done", 1'b0, 4);
        end
        wait_flag("run_done", 1'b1, 4);
        check("busy_at_run_done", {31'd0, busy}, 32'd1);
        @(negedge clk);
        check("busy_after_run_done", {31'd0, busy}, 32'd0);
        repeat (3) @(negedge clk);
        check("kick_count", kicks - k0, l - f + 1);
        check("writes_drained", exp_q.size(), 0);
    endtask

    logic [1:0]  bad_f[5]  = '{2'd2, 2'd0, 2'd0, 2'd0, 2'd0};
    logic [1:0]  bad_l[5]  = '{2'd1, 2'd3, 2'd0, 2'd0, 2'd0};
    logic [10:0] bad_w[5]  = '{11'd4, 11'd4, 11'd0, 11'd4, 11'd1025};
    logic [14:0] bad_d[5]  = '{15'd3, 15'd3, 15'd3, 15'd25601, 15'd3};

    initial begin
        int errs;
        int first_err;
        int t_errs;
        bit seen_a;
        bit seen_b;
        bit seen_c;
        bit early;

        // reset block
        repeat (3) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_outputs", {21'd0, s_ready, wea, sa_start, layer_done, run_done, err,
                              nth_conv, cur_layer, 1'b0}, 32'd0);
        check("rst_addra", {15'd0, addra}, 32'd0);
        rst = 1'b0;

        // directed single layer with sequential bytes
        do_run(2'd0, 2'd0, 4, 3, 1'b1, 1'b0);

        // three layers, random lengths and stream/accumulator gaps
        do_run(2'd0, 2'd2, $urandom_range(1, 24), $urandom_range(1, 40), 1'b0, 1'b1);

        // invalid configurations
        for (int t = 0; t < 5; t++) begin
            start_cmd(bad_f[t], bad_l[t], bad_w[t], bad_d[t]);
            errs = 0;
            seen_a = 1'b0;
            seen_b = 1'b0;
            for (int c = 0; c < 4; c++) begin
                errs += int'(err);
                seen_a |= busy;
                seen_b |= s_ready;
                @(negedge clk);
            end
            check("bad_cfg_err_pulses", errs, 1);
            check("bad_cfg_busy", {31'd0, seen_a}, 32'd0);
            check("bad_cfg_s_ready", {31'd0, seen_b}, 32'd0);
        end

        // abort in the middle of LOAD_D, with a byte accepted in the abort cycle
        start_cmd(2'd0, 2'd0, 11'd4, 15'd10);
        stream_layer(4, 7, 1'b0, 1'b0);
        @(negedge clk);
        s_valid   = 1'b1;
        s_data    = 8'hA5;
        cmd_abort = 1'b1;
        @(negedge clk);
        cmd_abort = 1'b0;
        s_valid   = 1'b0;
        check("abort_wea", {31'd0, wea}, 32'd0);
        check("abort_s_ready", {31'd0, s_ready}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_no_pulse", {29'd0, layer_done, run_done, err}, 32'd0);
        repeat (2) @(negedge clk);
        do_run(2'd0, 2'd0, 4, 3, 1'b0, 1'b0);

        // timeout on the short-timeout instance: layer 2 with only 195 pulses
        start_cmd(2'd2, 2'd2, 11'd1, 15'd1);
        stream_layer(1, 2, 1'b0, 1'b0);
        @(negedge clk);
        s_valid = 1'b0;
        wait_kick(2);
        first_err = -1;
        t_errs = 0;
        seen_a = 1'b0;
        seen_b = 1'b0;
        for (int c = 1; c <= 230; c++) begin
            @(negedge clk);
            if (t_err && first_err < 0) first_err = c;
            t_errs += int'(t_err);
            seen_a |= t_layer_done;
            seen_b |= layer_done;
            accu_valid_i = (c <= 195);
        end
        accu_valid_i = 1'b0;
        check("tmo_err_cycle", first_err, 101);
        check("tmo_err_pulses", t_errs, 1);
        check("tmo_no_layer_done", {31'd0, seen_a}, 32'd0);
        check("tmo_idle", {31'd0, t_busy}, 32'd0);
        check("short_count_no_done", {31'd0, seen_b}, 32'd0);
        check("short_count_still_busy", {31'd0, busy}, 32'd1);
        @(negedge clk);
        cmd_abort = 1'b1;
        @(negedge clk);
        cmd_abort = 1'b0;
        check("abort_compute_busy", {31'd0, busy}, 32'd0);

        // asynchronous reset during COMPUTE of layer 1
        start_cmd(2'd1, 2'd1, 11'd3, 15'd3);
        stream_layer(3, 6, 1'b0, 1'b0);
        @(negedge clk);
        s_valid = 1'b0;
        wait_kick(1);
        pulse_accu(10, 1'b0, early);
        check("pre_rst_busy", {31'd0, busy}, 32'd1);
        check("pre_rst_nth_conv", {30'd0, nth_conv}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_ctrl", {21'd0, s_ready, wea, sa_start, busy, layer_done, run_done,
                                 err, nth_conv, cur_layer}, 32'd0);
        check("async_rst_addra", {15'd0, addra}, 32'd0);
        check("async_rst_dia", {24'd0, dia}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        seen_a = 1'b0;
        seen_b = 1'b0;
        seen_c = 1'b0;
        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            seen_a |= layer_done;
            seen_b |= sa_start;
            seen_c |= busy;
            accu_valid_i = (c < 784);
        end
        accu_valid_i = 1'b0;
        check("post_rst_no_layer_done", {31'd0, seen_a}, 32'd0);
        check("post_rst_no_kick", {31'd0, seen_b}, 32'd0);
        check("post_rst_idle", {31'd0, seen_c}, 32'd0);

        repeat (3) @(negedge clk);
        check("final_queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sa_layer_sequencer.md
Name: sa_layer_sequencer

Overview:
Run-level controller in front of the systolic-array top.
- Accepts a host/DMA byte stream and writes it through the shared write port (wea/addra/dia), per layer: weights first, then feature data.
- Issues the array start pulse with the layer index, then counts accumulator-valid pulses to detect layer completion.
- Steps through a configured range of conv layers (0..2) and reports done or error.

Parameters:
TIMEOUT_CYC, 65535, max cycles in COMPUTE without completion before error abort
CNT_W, 17, width of the internal timeout counter

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
cmd_start  in  1  pulse: begin a run (ignored while busy)
cmd_abort  in  1  pulse: abandon run, return to IDLE
cfg_first_layer  in  2  first layer index
cfg_last_layer  in  2  last layer index
cfg_wgt_len  in  11  weight bytes per layer, 1..1024
cfg_dat_len  in  15  data bytes per layer, 1..25600
s_valid  in  1  stream byte valid
s_data  in  8  stream byte
s_ready  out  1  stream ready
wea  out  1  write enable to array top
addra  out  17  write address; [16:15]=01 weight, 00 data
dia  out  8  write data
sa_start  out  1  one-cycle start to array
nth_conv  out  2  layer index to array, stable from KICK until leaving COMPUTE
accu_valid_i  in  1  column-0 accumulator valid from array
busy  out  1  high in any state except IDLE
cur_layer  out  2  layer being processed
layer_done  out  1  one-cycle pulse per finished layer
run_done  out  1  one-cycle pulse after last layer
err  out  1  one-cycle pulse on config error or timeout

Behaviour:
- Reset (async): state IDLE; all outputs 0; counters 0.
- States: IDLE, LOAD_W, LOAD_D, DRAIN, KICK, COMPUTE, NEXT.
- IDLE, on cmd_start:
  - Latch all cfg_* inputs.
  - Config is invalid if any of: first>last, last==3, wgt_len==0 or >1024, dat_len==0 or >25600. On invalid config: err pulse, stay IDLE.
  - Otherwise: cur_layer=first, go to LOAD_W.
- LOAD_W:
  - s_ready=1. Each handshake (s_valid&s_ready) increments wcnt.
  - Next cycle (registered, latency 1): wea=1, addra={2'b01,5'b0,wcnt[9:0]}, dia=byte.
  - On the handshake with wcnt==wgt_len-1: wcnt clears, go to LOAD_D.
- LOAD_D: same as LOAD_W but addra={2'b00,dcnt[14:0]}. On the final byte go to DRAIN.
- DRAIN: s_ready=0 for one cycle so the last write lands; go to KICK.
- KICK: sa_start=1 and nth_conv=cur_layer for exactly one cycle; go to COMPUTE.
- COMPUTE:
  - Count accu_valid_i cycles in ocnt (11 bits). Expected count: 1024 for layer 0, 784 for layer 1, 196 for layer 2.
  - When ocnt reaches the expected count: layer_done pulse, go to NEXT.
  - If the timeout counter reaches TIMEOUT_CYC first: err pulse, go to IDLE.
- NEXT:
  - If cur_layer==last: run_done pulse, go to IDLE.
  - Else cur_layer+1, counters cleared, go to LOAD_W.
- s_ready=0 outside LOAD_W/LOAD_D. wea=0 except the cycle after a handshake.
- accu_valid_i is ignored outside COMPUTE; extra pulses after completion are not counted.
- cmd_abort has priority over all transitions. Next cycle: IDLE, s_ready=0, wea=0, no done/err pulse. An in-flight registered write is suppressed.
- cmd_start while busy: ignored. cmd_start and cmd_abort together in IDLE: abort wins, nothing starts.
- Back-pressure-free: stream gaps (s_valid=0) simply stall the counters.
- Reset mid-run: immediate IDLE; the array is not re-kicked.

Test Plan:
- Config first=0,last=0,wgt=4,dat=3, bytes 1..7 streamed continuously -> wea writes to addra 0x08000..0x08003 with data 1..4, then 0x00000..0x00002 with data 5..7. One sa_start with nth_conv=0. After 1024 accu_valid_i pulses: layer_done, then run_done. busy drops the cycle after run_done.
- Run first=0,last=2 with random s_valid gaps -> three sa_start pulses with nth_conv 0,1,2. Completion after exactly 1024/784/196 valid pulses. Three layer_done pulses, one run_done.
- Invalid configs (first=2,last=1; last=3; wgt_len=0; dat_len=25601) -> err pulse, busy stays 0, s_ready stays 0.
- Only 195 valid pulses in layer 2 with TIMEOUT_CYC=100 -> err pulse 100 cycles into COMPUTE, return to IDLE, no layer_done.
- cmd_abort mid LOAD_D -> next cycle wea=0, s_ready=0, busy=0. A new cmd_start restarts at LOAD_W with addra 0x08000.
- Async rst asserted during COMPUTE -> all outputs 0 immediately. accu_valid_i pulses after reset cause no layer_done.
